// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner, debouncer and operand-entry FSM
// feeding num1/num2/func/button of the calculation core.
// Optional feature macro: KEYPAD_EXT_FUNC_EN (repeat operator in NUM2 toggles func[2]).
module keypad_entry #(
  parameter int SCAN_CYCLES = 5000,
  parameter int DEB_SCANS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] key_row,
  input  logic [3:0] key_col,
  output logic [7:0] num1,
  output logic [7:0] num2,
  output logic [2:0] func,
  output logic       button,
  output logic [1:0] state
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEB_SCANS + 1);

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_NUM2 = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // scanner
  logic [SW-1:0] r_slot;
  logic [1:0]    r_row;
  logic [1:0]    r_nlow;      // low columns seen so far this frame, saturating at 2
  logic [3:0]    r_key;       // index of the single low column seen this frame
  logic [2:0]    w_col_lows;
  logic [1:0]    w_col_idx;
  logic [2:0]    w_nlow_sum;
  logic          w_last_slot;
  logic          w_frame_end;
  logic          w_frame_valid;
  logic [3:0]    w_frame_key;

  // debounce
  logic          r_prev_valid;
  logic [3:0]    r_prev_key;
  logic [DW-1:0] r_deb_cnt;
  logic          r_pressed;
  logic          r_armed;     // cleared by reset so a key held through reset must be released first
  logic          r_event;
  logic [3:0]    r_event_key;
  logic          w_same;
  logic [DW-1:0] w_cnt_next;
  logic          w_stable;

  // entry FSM
  state_t        r_state, w_state_next;
  logic [7:0]    r_num1, r_num2, w_num1_next, w_num2_next;
  logic [2:0]    r_func, w_func_next;
  logic          r_button, w_button_next;
  logic [1:0]    w_ev_col;
  logic [3:0]    w_digit;
  logic [7:0]    w_operand;
  logic [11:0]   w_prod;
  logic          w_fits;

  assign w_last_slot = (r_slot == SW'(SCAN_CYCLES - 1));
  assign w_frame_end = w_last_slot && (r_row == 2'd3);

  // count low column bits in the current sample and locate the low one
  always_comb begin
    w_col_lows = '0;
    w_col_idx  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (!key_col[c]) begin
        w_col_lows = w_col_lows + 3'd1;
        w_col_idx  = 2'(c);
      end
    end
  end

  assign w_nlow_sum    = {1'b0, r_nlow} + w_col_lows;
  assign w_frame_valid = (w_nlow_sum == 3'd1);
  assign w_frame_key   = (w_col_lows == 3'd1) ? {r_row, w_col_idx} : r_key;

  // row rotation, slot timing and per-frame accumulation of column samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
      r_row  <= '0;
      r_nlow <= '0;
      r_key  <= '0;
    end else if (w_last_slot) begin
      r_slot <= '0;
      r_row  <= r_row + 2'd1;
      if (r_row == 2'd3) begin
        r_nlow <= '0;
        r_key  <= '0;
      end else begin
        r_nlow <= (w_nlow_sum >= 3'd2) ? 2'd2 : w_nlow_sum[1:0];
        r_key  <= w_frame_key;
      end
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  assign key_row = ~(4'b0001 << r_row);

  assign w_same     = (w_frame_valid == r_prev_valid) &&
                      (!w_frame_valid || (w_frame_key == r_prev_key));
  assign w_cnt_next = !w_same ? DW'(1) :
                      (r_deb_cnt == DW'(DEB_SCANS)) ? r_deb_cnt : r_deb_cnt + 1'b1;
  assign w_stable   = (w_cnt_next == DW'(DEB_SCANS));

  // frame-level debounce: one event per accepted press, release re-arms
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_valid <= 1'b0;
      r_prev_key   <= '0;
      r_deb_cnt    <= '0;
      r_pressed    <= 1'b0;
      r_armed      <= 1'b0;
      r_event      <= 1'b0;
      r_event_key  <= '0;
    end else begin
      r_event <= 1'b0;
      if (w_frame_end) begin
        r_prev_valid <= w_frame_valid;
        r_prev_key   <= w_frame_key;
        r_deb_cnt    <= w_cnt_next;
        if (w_stable && w_frame_valid && !r_pressed && r_armed) begin
          r_event     <= 1'b1;
          r_event_key <= w_frame_key;
          r_pressed   <= 1'b1;
        end
        if (w_stable && !w_frame_valid) begin
          r_pressed <= 1'b0;
          r_armed   <= 1'b1;
        end
      end
    end
  end

  // key index 4r+c: column 3 is an operator, 12 '*', 13 '0', 14 '#'
  assign w_ev_col  = r_event_key[1:0];
  assign w_digit   = (r_event_key == 4'd13) ? 4'd0 :
                     4'(r_event_key[3:2]) * 4'd3 + 4'(r_event_key[1:0]) + 4'd1;
  assign w_operand = (r_state == S_NUM2) ? r_num2 : r_num1;
  assign w_prod    = 12'(w_operand) * 12'd10 + 12'(w_digit);
  assign w_fits    = (w_prod <= 12'd255);

  // entry FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_NUM1;
      r_num1   <= '0;
      r_num2   <= '0;
      r_func   <= '0;
      r_button <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_num1   <= w_num1_next;
      r_num2   <= w_num2_next;
      r_func   <= w_func_next;
      r_button <= w_button_next;
    end
  end

  // entry FSM next state and operand updates on key events
  always_comb begin
    w_state_next  = r_state;
    w_num1_next   = r_num1;
    w_num2_next   = r_num2;
    w_func_next   = r_func;
    w_button_next = 1'b0;
    if (r_event) begin
      if (r_event_key == 4'd12) begin
        w_num1_next  = '0;
        w_num2_next  = '0;
        w_func_next  = '0;
        w_state_next = S_NUM1;
      end else if (r_event_key == 4'd14) begin
        if (r_state != S_NUM1) begin
          w_button_next = 1'b1;
          w_state_next  = S_DONE;
        end
      end else if (w_ev_col == 2'd3) begin
        if (r_state == S_NUM2) begin
`ifdef KEYPAD_EXT_FUNC_EN
          if (r_func[1:0] == r_event_key[3:2])
            w_func_next = {~r_func[2], r_event_key[3:2]};
          else
            w_func_next = {1'b0, r_event_key[3:2]};
`else
          w_func_next = {1'b0, r_event_key[3:2]};
`endif
        end else begin
          w_func_next  = {1'b0, r_event_key[3:2]};
          w_num2_next  = '0;
          w_state_next = S_NUM2;
        end
      end else begin
        case (r_state)
          S_NUM1: if (w_fits) w_num1_next = w_prod[7:0];
          S_NUM2: if (w_fits) w_num2_next = w_prod[7:0];
          default: begin
            w_num1_next  = {4'b0, w_digit};
            w_num2_next  = '0;
            w_state_next = S_NUM1;
          end
        endcase
      end
    end
  end

  assign num1   = r_num1;
  assign num2   = r_num2;
  assign func   = r_func;
  assign button = r_button;
  assign state  = r_state;

endmodule

// File: doc/keypad_entry.md
# keypad_entry

- Operand-entry front end for the calculator datapath.
- Scans a 4x4 matrix keypad, debounces it and assembles decimal operands and an operator.
- Drives the `num1` / `num2` / `func` / `button` inputs of the calculation core, replacing the switch-and-button entry path.
- Runs on the divided system clock alongside the calculation and display blocks.

## Interface

Parameters:
- `SCAN_CYCLES`, default 5000: clock cycles each row is driven per scan slot (≥2).
- `DEB_SCANS`, default 4: consecutive identical full-scan frames required to accept a press or release (≥1).

Ports:
- `clk`, input, 1: the single clock (divided system clock).
- `rst`, input, 1: synchronous, active-high reset.
- `key_row`, output, 4: keypad row drive, active low, one row low at a time.
- `key_col`, input, 4: keypad column sense, active low (pulled up externally).
- `num1`, output, 8: first operand, unsigned binary.
- `num2`, output, 8: second operand, unsigned binary.
- `func`, output, 3: operator code.
- `button`, output, 1: one-cycle start pulse ("equals") to the calculation core.
- `state`, output, 2: entry state; 0 = NUM1, 1 = NUM2, 2 = DONE.

## Operation

Scanning:
- Row counter `r` advances 0→1→2→3→0 every `SCAN_CYCLES` cycles.
- `key_row` drives row `r` low (0 → 4'b1110, 1 → 4'b1101, 2 → 4'b1011, 3 → 4'b0111).
- `key_col` is sampled on the last cycle of each row slot; one frame is 4 slots.
- Frame result:
  - exactly one low column across the whole frame → key index k = 4r+c, where c is the column whose bit is low;
  - zero low columns, or more than one key → "no key".
- Key map, rows 0..3, columns 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D

Debounce:
- Count consecutive identical frame results, saturating at `DEB_SCANS`.
- A key event fires once, when a key result reaches `DEB_SCANS` consecutive frames and the debounced state is currently "released".
- The debounced state returns to "released" only after `DEB_SCANS` consecutive no-key frames.
- A held key produces exactly one event; there is no auto-repeat.

Entry FSM (acts on key events only):
- Digit d:
  - NUM1: num1 = num1*10+d.
  - NUM2: num2 = num2*10+d.
  - DONE: num1 = d, num2 = 0, go NUM1.
  - Saturation rule: the product is computed 12 bits wide; if it exceeds 255 the digit is ignored and the operand is unchanged.
- Operator A/B/C/D sets func = {1'b0, 2'd0/1/2/3}:
  - NUM1: num2 = 0, go NUM2.
  - NUM2: replaces func; num2 is kept.
  - DONE: num2 = 0, go NUM2; num1 is kept for chained operations.
- '#':
  - NUM1: ignored.
  - NUM2: pulse `button` for one cycle, go DONE.
  - DONE: pulse `button` again, state stays DONE.
- '*': num1 = 0, num2 = 0, func = 0, go NUM1, from any state.

## Timing

- Reset values: `key_row` = 4'b1110, `num1` = 0, `num2` = 0, `func` = 0, `button` = 0, `state` = 0. The row counter, slot counter, debounce counters and debounced state are cleared, with the debounced state set to "released".
- The key event is asserted the cycle after the frame's final sample.
- `num1` / `num2` / `func` / `state` update, and `button` rises, on the clock edge following the event.
- `button` is high for exactly one cycle. `num1`, `num2` and `func` are already stable on the cycle `button` is high, and remain stable until the next key event.
- Minimum press-to-event latency is `DEB_SCANS` frames = `DEB_SCANS`*4*`SCAN_CYCLES` cycles, plus 1.
- Reset asserted mid-frame or mid-press aborts everything. After release, a key still held must first be seen as released for `DEB_SCANS` frames before it generates an event.
- Only one event is possible per frame, so simultaneous key events cannot occur.

## Configuration

- `KEYPAD_EXT_FUNC_EN`
  - Defined: pressing the operator key equal to the current func[1:0] while in NUM2 toggles func[2], giving access to functions 4–7. Any other operator key sets func[2] = 0.
  - Undefined: func[2] is constantly 0, and a repeated operator key is a no-op.

## Test plan

All scenarios use `SCAN_CYCLES` = 4 and `DEB_SCANS` = 2.

1. Reset → `key_row` = 4'b1110, rotating to 4'b1101 after 4 cycles. All other outputs are 0 and no `button` pulse occurs with no key pressed.
2. Keys 1,2,3,A,4,5,# → `num1` = 123, `func` = 0, `num2` = 45, a single-cycle `button` pulse, `state` = 2. A further '#' produces a second pulse with operands unchanged.
3. Saturation: 2,5,6 → `num1` = 25 (the 6 is ignored); '*', then 2,5,5 → `num1` = 255.
4. Bounce and hold:
   - key present for 1 frame, absent, present for 1 frame → no event;
   - key held 50 frames → exactly one event;
   - two keys held together → no event.
5. Clear and reset: 7,B,8 then '*' → all operands 0, `state` = 0. Raising `rst` while 9 is held → outputs go to reset values, and 9 does not register until it has been released and pressed again.
6. With `KEYPAD_EXT_FUNC_EN`: 3,C,C → `func` = 6; C again → `func` = 2. Without the macro: 3,C,C → `func` = 2.
